// File: rtl/fp32_pkg.sv
// Shared FP32 datapath definitions: field layout, special constants, the
// divider FSM state type and the operand unpack helper used by add/sub and div.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [31:0]      POS_INF = 32'h7F80_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fsm_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  function automatic fp32_t unpack(input logic [31:0] x);
    fp32_t f;
    f.sign = x[31];
    f.exp  = x[30:23];
    f.mant = x[22:0];
    return f;
  endfunction

endpackage

// File: rtl/fp32_div_step.sv
// One restoring-division iteration: compare, conditionally subtract, shift left.
module fp32_div_step (
  input  logic [25:0] rem,
  input  logic [23:0] div,
  output logic [25:0] rem_next,
  output logic        q_bit
);

  logic [25:0] div_ext;
  logic [25:0] diff;

  assign div_ext = {2'b00, div};
  assign diff    = rem - div_ext;
  assign q_bit   = (rem >= div_ext);

  // The remainder stays below 2*div, so dropping bit 25 on the shift loses nothing.
  assign rem_next = q_bit ? {diff[24:0], 1'b0} : {rem[24:0], 1'b0};

endmodule

// File: rtl/fp32_div_seq.sv
// Iterative FP32 divider, one quotient bit per clock, truncating result,
// with valid/ready handshakes on both the operand and the result side.
module fp32_div_seq
  import fp32_pkg::*;
#(
  parameter logic [31:0] NAN_VALUE = QNAN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        exception,
  output logic        div_by_zero
);

  localparam int         ITERS     = 25;
  localparam logic [4:0] CNT_START = 5'(ITERS - 1);

  fsm_state_t         state_q;
  logic [25:0]        rem_q;
  logic [23:0]        div_q;
  logic [ITERS-1:0]   quo_q;
  logic [4:0]         cnt_q;
  logic signed [9:0]  exp_q;
  logic               sign_q;
  logic [31:0]        res_q;
  logic               exc_q;
  logic               dbz_q;
  logic               out_valid_q;

  fp32_t              op_a;
  fp32_t              op_b;
  logic               sign_in;
  logic signed [9:0]  exp_init;
  logic [25:0]        rem_d;
  logic               q_bit;
  logic signed [9:0]  norm_exp;
  logic [22:0]        norm_mant;
  logic [31:0]        norm_res;

  assign op_a     = unpack(a);
  assign op_b     = unpack(b);
  assign sign_in  = op_a.sign ^ op_b.sign;
  assign exp_init = $signed({2'b00, op_a.exp}) - $signed({2'b00, op_b.exp})
                  + $signed(10'(BIAS));

  fp32_div_step u_step (
    .rem      (rem_q),
    .div      (div_q),
    .rem_next (rem_d),
    .q_bit    (q_bit)
  );

  // Quotient lies in [0.5, 2); a clear top bit means one extra left shift.
  always_comb begin
    norm_exp  = exp_q;
    norm_mant = quo_q[23:1];
    if (!quo_q[24]) begin
      norm_exp  = exp_q - 10'sd1;
      norm_mant = quo_q[22:0];
    end
    if (norm_exp >= 10'sd255) begin
      norm_res = {sign_q, POS_INF[30:0]};
    end else if (norm_exp <= 10'sd0) begin
      norm_res = {sign_q, 31'h0};
    end else begin
      norm_res = {sign_q, norm_exp[7:0], norm_mant};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      res_q       <= '0;
      exc_q       <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= sign_in;
            if (op_a.exp == EXP_MAX || op_b.exp == EXP_MAX) begin
              res_q       <= NAN_VALUE;
              exc_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (op_b.exp == '0) begin
              res_q       <= {sign_in, EXP_MAX, 23'h0};
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (op_a.exp == '0) begin
              res_q       <= {sign_in, 31'h0};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              rem_q   <= {2'b00, 1'b1, op_a.mant};
              div_q   <= {1'b1, op_b.mant};
              quo_q   <= '0;
              cnt_q   <= CNT_START;
              exp_q   <= exp_init;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          rem_q <= rem_d;
          // Bits arrive MSB first, so shifting in lands each at q[cnt].
          quo_q <= {quo_q[ITERS-2:0], q_bit};
          if (cnt_q == '0) begin
            state_q <= NORM;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        NORM: begin
          res_q       <= norm_res;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            exc_q       <= 1'b0;
            dbz_q       <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign res         = res_q;
  assign exception   = exc_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Self-checking bench for fp32_div_seq: directed cases plus randomized operands
// compared against an integer-arithmetic model of truncating FP32 division.
module tb_fp32_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        exception;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp32_div_seq dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res         (res),
    .exception   (exception),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, want);
    end
  endtask

  // Reference: quotient of the significands as a plain integer division.
  task automatic ref_div(input logic [31:0] ta, input logic [31:0] tb_op,
                         output logic [31:0] r, output logic exc, output logic dbz,
                         output int lat);
    int          ea, eb, e;
    longint      ma, mb, q, m;
    logic        s;
    ea  = int'(ta[30:23]);
    eb  = int'(tb_op[30:23]);
    s   = ta[31] ^ tb_op[31];
    exc = 1'b0;
    dbz = 1'b0;
    lat = 1;
    if (ea == 255 || eb == 255) begin
      r   = 32'h7FC0_0000;
      exc = 1'b1;
    end else if (eb == 0) begin
      r   = {s, 8'hFF, 23'h0};
      dbz = 1'b1;
    end else if (ea == 0) begin
      r = {s, 31'h0};
    end else begin
      lat = 27;
      ma  = longint'(ta[22:0]) + (longint'(1) << 23);
      mb  = longint'(tb_op[22:0]) + (longint'(1) << 23);
      q   = (ma << 24) / mb;
      e   = ea - eb + 127;
      if (q >= (longint'(1) << 24)) begin
        m = (q >> 1) % (longint'(1) << 23);
      end else begin
        m = q % (longint'(1) << 23);
        e = e - 1;
      end
      if (e >= 255)     r = {s, 8'hFF, 23'h0};
      else if (e <= 0)  r = {s, 31'h0};
      else              r = {s, 8'(e), 23'(m)};
    end
  endtask

  // Full transaction: accept, wait for result, optional backpressure, handshake.
  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_op,
                       input int hold);
    logic [31:0] want;
    logic        w_exc, w_dbz;
    int          w_lat, edges;
    ref_div(ta, tb_op, want, w_exc, w_dbz, w_lat);
    edges = 0;
    while (!in_ready && edges < 100) begin
      @(posedge clk); #1; edges++;
    end
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1; edges++;
    end
    check({tag, ".latency"}, 32'(edges), 32'(w_lat));
    check({tag, ".res"}, res, want);
    check({tag, ".exc"}, 32'(exception), 32'(w_exc));
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(w_dbz));
    $display("op %s a=%08h b=%08h res=%08h exc=%0b dbz=%0b lat=%0d", tag, ta, tb_op, res,
             exception, div_by_zero, edges);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_res"}, res, want);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".post_exc"}, 32'(exception), 32'd0);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int sel;
    sel = int'($urandom_range(0, 15));
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else if (sel == 2) e = 8'(($urandom_range(0, 1) == 0) ? 8'hFE : 8'h01);
    else               e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.res", res, 32'd0);
    check("reset.exc", 32'(exception), 32'd0);
    check("reset.dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op("six_by_two", 32'h40C0_0000, 32'h4000_0000, 0);
    do_op("one_by_three", 32'h3F80_0000, 32'h4040_0000, 0);
    do_op("div_zero", 32'hC000_0000, 32'h0000_0000, 0);
    do_op("inf_operand", 32'h7F80_0000, 32'h3F80_0000, 0);
    do_op("overflow", 32'h7F00_0000, 32'h3E80_0000, 0);
    do_op("zero_a", 32'h8000_0000, 32'h3F80_0000, 0);
    do_op("underflow", 32'h0080_0000, 32'h4000_0000, 0);
    do_op("backpressure", 32'h40C0_0000, 32'h4000_0000, 5);

    // Reset in the middle of the iteration discards the operation.
    a = 32'h40C0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_reset.in_ready", 32'(in_ready), 32'd1);
    check("mid_reset.out_valid", 32'(out_valid), 32'd0);
    $display("op mid_reset in_ready=%0b out_valid=%0b", in_ready, out_valid);
    do_op("after_reset", 32'h40C0_0000, 32'h4000_0000, 0);

    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rand%0d", i), rand_fp(), rand_fp(), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
- Iterative IEEE-754 single-precision divider, res = a / b, in the same FP32 datapath family as the combinational add/sub unit.
- Uses one restoring-division step per clock with a valid/ready handshake on the input side and the output side.
- Follows the add/sub unit's format rules:
  - truncation, i.e. round toward zero;
  - an exponent field of 255 on either operand raises `exception`.
- Sits beside the adder in the arithmetic cluster.

Parameters:
- NAN_VALUE, 32'h7FC0_0000, result pattern driven when `exception` is raised.
- ITERS, 25, number of quotient bits produced; fixed for FP32, and the RTL must not support other values.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- in_valid  input  1  operands a and b are presented
- in_ready  output  1  divider can accept operands
- a  input  32  FP32 dividend
- b  input  32  FP32 divisor
- out_valid  output  1  res and flags are valid
- out_ready  input  1  consumer takes the result
- res  output  32  FP32 quotient
- exception  output  1  a[30:23]==255 or b[30:23]==255
- div_by_zero  output  1  b is zero or denormal (exp_b==0) and exception is 0

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, in_ready=1, out_valid=0, res=0, exception=0, div_by_zero=0.
- FSM has four states: IDLE, DIV, NORM, DONE. in_ready = (state==IDLE) exactly.
- IDLE: an accept is in_valid & in_ready at a rising edge. On accept, latch operands and classify, in this priority:
  1. exp_a==255 or exp_b==255: res=NAN_VALUE, exception=1, go to DONE.
  2. exp_b==0: res={sa^sb, 8'hFF, 23'h0}, div_by_zero=1, go to DONE.
  3. exp_a==0: res={sa^sb, 31'h0}, go to DONE. Denormals are flushed to zero.
  4. Otherwise: rem={2'b0,1,mant_a} (26 bit), div={1,mant_b}, q=0, cnt=24, e=exp_a-exp_b+127 as signed 10 bit. Go to DIV.
- DIV, one step per cycle:
  - If rem>=div then q[cnt]=1 and rem=(rem-div)<<1; else q[cnt]=0 and rem=rem<<1.
  - Go to NORM after the cnt==0 step. Otherwise cnt--.
- NORM, one cycle:
  - If q[24]: mant=q[23:1], exp=e. Else: mant=q[22:0], exp=e-1.
  - exp>=255 → res={s,8'hFF,23'h0}. There is no flag for overflow.
  - exp<=0 → res={s,31'h0}.
  - Otherwise res={s,exp[7:0],mant}.
  - Go to DONE.
- DONE: out_valid=1. res and flags are held stable until out_valid & out_ready. On that handshake go to IDLE, then clear out_valid and the flags.
- Latency from the accept edge:
  - normal path: out_valid high after the 27th edge (1 classify + 25 DIV + 1 NORM);
  - special cases: out_valid high after the 1st edge.
- Throughput: the next accept is possible no earlier than the edge after the output handshake, because in_ready is only high in IDLE. No overlap.
- Backpressure: out_ready low holds DONE indefinitely, with in_ready=0.
- reset during DIV, NORM or DONE: return to IDLE. Any in-flight result is discarded and outputs return to their reset values.
- Sign s=a[31]^b[31] for every non-NaN result, including zero and inf.

Decomposition:
- Shared package fp32_pkg holds:
  - the field widths (EXP_W=8, MANT_W=23) and BIAS=127;
  - the constants QNAN, POS_INF and EXP_MAX;
  - the fsm_state_t enum;
  - the unpack helper (sign/exp/mant) shared with the add/sub unit.
- One sub-module is natural: fp32_div_step. It is the combinational compare/subtract/shift of one iteration, with inputs rem and div and outputs rem_next and q_bit.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000 → res=0x40400000, flags 0, out_valid exactly 27 edges after accept.
- 1.0/3.0: a=0x3F800000, b=0x40400000 → res=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- Divide by zero: a=0xC0000000, b=0x00000000 → res=0xFF800000, div_by_zero=1, exception=0, out_valid after 1 edge.
- Inf/NaN operand: a=0x7F800000, b=0x3F800000 → res=0x7FC00000, exception=1. Overflow: a=0x7F000000, b=0x3E800000 → res=0x7F800000, no flag.
- Backpressure and reset: hold out_ready=0 for 5 cycles in DONE → res stable, in_ready=0. Assert reset at DIV cycle 10 → next edge in_ready=1, out_valid=0; a fresh 6.0/2.0 still yields 0x40400000.
